sbox_loader: RTL and testbench
==============================

# sbox_loader

Streams the 256-byte AES S-box table into the `sbox_lut` table port from a 32-bit word interface. It assembles the flattened 2048-bit table and pulses `sbox_in_vld` once on commit. It then waits for the table's `sbox_available` acknowledge and holds `sbox_ready` for the cipher control logic. It sits between the chip's configuration/boot word source and `sbox_lut`, and owns the writer side of the `sbox_in`/`sbox_in_vld`/`sbox_available` interface.

## Interface
- `WORDS`, 64: words per table load (256 bytes / 4); the counter is 6 bits wide.
- `ACK_TIMEOUT`, 8: cycles to wait in WAIT_ACK for `sbox_available` before flagging an error.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `load_start` input 1: one-cycle pulse that begins (or restarts) a table load.
- `load_word` input 32 (`WORD_DATA_WIDTH`): table word k. Bits [7:0] carry S(4k), [15:8] S(4k+1), [23:16] S(4k+2), [31:24] S(4k+3).
- `load_word_vld` input 1: `load_word` is valid.
- `load_word_rdy` output 1: the loader accepts a word this cycle.
- `sbox_in` output 2048 (`sbox_w*sbox_h*8`): flattened table. Byte n occupies bits [8n+7:8n] and holds S(n). Row r, column c means n = 16r + c.
- `sbox_in_vld` output 1: one-cycle commit strobe to `sbox_lut`.
- `sbox_available` input 1: acknowledge from `sbox_lut`, registered from `sbox_in_vld`.
- `sbox_ready` output 1: the table is committed and acknowledged, so the cipher may issue lookups.
- `load_err` output 1: sticky. No acknowledge arrived within `ACK_TIMEOUT` cycles.
- `load_xsum` output 32: running XOR of all words accepted in the current load.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: accepting words.
  - COMMIT: issuing the commit strobe.
  - WAIT_ACK: waiting for the acknowledge.
  - READY: table loaded.
  - ERROR: acknowledge timed out.
- IDLE, READY or ERROR with `load_start`=1 → LOAD. On this transition the word counter clears to 0, `load_xsum` clears to 0, `sbox_ready` clears to 0 and `load_err` clears to 0.
- LOAD:
  - `load_word_rdy`=1. A word is accepted when `load_word_vld && load_word_rdy`.
  - On acceptance, `sbox_in[32k+31:32k] <= load_word`, `load_xsum <= load_xsum ^ load_word`, and k increments.
  - Acceptance with k=63 → COMMIT.
- `load_start` during LOAD restarts the load:
  - k goes to 0 and `load_xsum` goes to 0.
  - Any word presented in the same cycle is dropped, and the state stays in LOAD.
  - `sbox_in` is not cleared; every word position is overwritten before the next commit.
- COMMIT: `sbox_in_vld`=1 for exactly this cycle, with `sbox_in` complete and stable. Next state is WAIT_ACK with the timeout counter at 0.
- WAIT_ACK:
  - `sbox_available`=1 → READY, with `sbox_ready`=1.
  - Otherwise the timeout counter increments. When it reaches `ACK_TIMEOUT` → ERROR, with `load_err`=1.
- READY and ERROR hold until `load_start` arrives.
- `load_start` in COMMIT or WAIT_ACK is ignored. The commit completes first; software re-issues the start afterwards.
- `load_word_rdy`=0 in every state other than LOAD. Words offered in those states are not consumed.
- `sbox_in` holds its last committed value in every state until it is overwritten by a new LOAD. `sbox_lut` captures it only on `sbox_in_vld`.

## Timing
- Reset values:
  - state = IDLE.
  - `sbox_in` = 0.
  - `sbox_in_vld` = 0, `load_word_rdy` = 0, `sbox_ready` = 0, `load_err` = 0.
  - `load_xsum` = 0, word counter = 0, timeout counter = 0.
- Reset asserted mid-load or mid-commit aborts immediately to the reset values. The next load needs a fresh `load_start`.
- `load_start` at cycle t → `load_word_rdy`=1 from t+1.
- Word throughput is one per cycle with back-to-back valid; gaps in `load_word_vld` are allowed.
- Last word accepted at cycle t → `sbox_in_vld`=1 at t+1.
- `sbox_available` from `sbox_lut` arrives at t+2 → `sbox_ready`=1 from t+3.
- Minimum load-to-ready latency: 1 + 64 + 3 = 68 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- Full load: reset, `load_start`, then 64 back-to-back words carrying the standard AES S-box (word 0 = 32'h7b777c63).
  - `sbox_in_vld` pulses once, 1 cycle after the last word.
  - `sbox_in[7:0]`=8'h63, `sbox_in[2047:2040]`=8'h16.
  - `sbox_ready`=1 at 68 cycles.
  - A `sbox_lut` lookup of 8'h53 returns 8'hed.
- Throttled load: `load_word_vld` toggles every other cycle. The same final table is produced, `sbox_in_vld` pulses 1 cycle after the 64th acceptance, and `load_xsum` equals the XOR of all 64 words.
- Restart: `load_start` after 20 words, then 64 new words (all 32'hA5A5A5A5).
  - `sbox_in` ends with every byte 8'hA5.
  - `load_xsum`=0.
  - Exactly one `sbox_in_vld` pulse.
- Ack timeout: tie `sbox_available`=0. `load_err`=1 exactly 8 cycles after entering WAIT_ACK, with `sbox_ready`=0. A following `load_start` clears `load_err`.
- Reset mid-load: assert `reset` after word 30.
  - All outputs return to 0 asynchronously.
  - Words offered after reset release are not accepted (`load_word_rdy`=0) until `load_start`.
- Reload from READY: a second full load drops `sbox_ready` to 0 in the cycle after `load_start` and re-asserts it 68 cycles later with the new table.

Source files
------------

// File: rtl/sbox_loader.sv
// sbox_loader: streams 64 words of the AES S-box into the flattened sbox_lut table port,
// commits it with a one-cycle strobe and waits (with timeout) for the table's acknowledge.
module sbox_loader #(
   parameter int WORDS           = 64,
   parameter int ACK_TIMEOUT     = 8,
   parameter int WORD_DATA_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               load_start,
   input  logic [WORD_DATA_WIDTH-1:0]         load_word,
   input  logic                               load_word_vld,
   output logic                               load_word_rdy,
   output logic [WORDS*WORD_DATA_WIDTH-1:0]   sbox_in,
   output logic                               sbox_in_vld,
   input  logic                               sbox_available,
   output logic                               sbox_ready,
   output logic                               load_err,
   output logic [WORD_DATA_WIDTH-1:0]         load_xsum
);
   localparam int KW = $clog2(WORDS);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, COMMIT, WAIT_ACK, READY, ERROR} state_t;

   state_t state, next;
   logic [KW-1:0] k;
   logic [TW-1:0] tcnt;
   logic accept, clr;

   // a start in LOAD wins over a word offered in the same cycle
   assign accept = state == LOAD && load_word_vld && !load_start;
   assign clr    = load_start && next == LOAD;

   always_comb begin
      next = state;
      case (state)
         IDLE, READY, ERROR: next = load_start ? LOAD : state;
         LOAD:     next = (accept && k == KW'(WORDS - 1)) ? COMMIT : LOAD;
         COMMIT:   next = WAIT_ACK;
         WAIT_ACK: next = sbox_available ? READY : (tcnt == TW'(ACK_TIMEOUT - 1)) ? ERROR : WAIT_ACK;
         default:  next = IDLE;
      endcase
   end

   // outputs are registered decodes of the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         k             <= '0;
         tcnt          <= '0;
         sbox_in       <= '0;
         load_xsum     <= '0;
         load_word_rdy <= 1'b0;
         sbox_in_vld   <= 1'b0;
         sbox_ready    <= 1'b0;
         load_err      <= 1'b0;
      end else begin
         state         <= next;
         load_word_rdy <= next == LOAD;
         sbox_in_vld   <= next == COMMIT;
         sbox_ready    <= next == READY;
         load_err      <= next == ERROR;
         tcnt          <= (state == WAIT_ACK) ? tcnt + 1'b1 : '0;
         if (clr) begin
            k         <= '0;
            load_xsum <= '0;
         end else if (accept) begin
            sbox_in[WORD_DATA_WIDTH*k +: WORD_DATA_WIDTH] <= load_word;
            load_xsum <= load_xsum ^ load_word;
            k         <= k + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sbox_loader.sv
// tb_sbox_loader: directed bench for sbox_loader with a small sbox_lut model
// (captures on sbox_in_vld, acknowledges one cycle later).
module tb_sbox_loader;
   logic clk = 1'b0, reset = 1'b0, load_start = 1'b0, load_word_vld = 1'b0;
   logic [31:0] load_word = '0;
   logic load_word_rdy, sbox_in_vld, sbox_available, sbox_ready, load_err;
   logic [2047:0] sbox_in, lut;
   logic [31:0] load_xsum;
   logic avail = 1'b0, ack_en = 1'b1, ready_after_start;
   int total = 0, bad = 0, cyc = 0, vld_cnt = 0, cyc_start = 0, v0 = 0;

   logic [7:0] sb [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   sbox_loader dut (
      .clk(clk), .reset(reset), .load_start(load_start), .load_word(load_word),
      .load_word_vld(load_word_vld), .load_word_rdy(load_word_rdy), .sbox_in(sbox_in),
      .sbox_in_vld(sbox_in_vld), .sbox_available(sbox_available), .sbox_ready(sbox_ready),
      .load_err(load_err), .load_xsum(load_xsum));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      avail <= sbox_in_vld;
      if (sbox_in_vld) begin
         lut <= sbox_in;
         vld_cnt <= vld_cnt + 1;
      end
   end
   assign sbox_available = avail & ack_en;

   // table 0: AES S-box, 1: its bitwise inverse, 2: all 8'hA5
   function automatic logic [31:0] word_of(input int t, input int k);
      logic [31:0] w;
      w = {sb[4*k+3], sb[4*k+2], sb[4*k+1], sb[4*k]};
      return t == 0 ? w : t == 1 ? ~w : 32'ha5a5a5a5;
   endfunction

   function automatic logic [2047:0] tbl_of(input int t);
      logic [2047:0] r;
      for (int k = 0; k < 64; k++) r[32*k +: 32] = word_of(t, k);
      return r;
   endfunction

   function automatic logic [31:0] xor_of(input int t);
      logic [31:0] x;
      x = '0;
      for (int k = 0; k < 64; k++) x ^= word_of(t, k);
      return x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start();
      load_start = 1'b1;
      cyc_start = cyc;
      @(negedge clk);
      load_start = 1'b0;
      ready_after_start = sbox_ready;
   endtask

   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      load_word = w;
      load_word_vld = 1'b1;
      while (!load_word_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("rdy_wait", 64'(load_word_rdy), 64'd1);
      @(negedge clk);
   endtask

   // returns at the negedge right after the 64th acceptance
   task automatic load(input int t, input bit gap);
      start();
      for (int k = 0; k < 64; k++) begin
         send(word_of(t, k));
         if (gap && k < 63) begin
            load_word_vld = 1'b0;
            @(negedge clk);
         end
      end
      load_word_vld = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 64'(load_word_rdy), 0);
      chk("rst_vld", 64'(sbox_in_vld), 0);
      chk("rst_ready", 64'(sbox_ready), 0);
      chk("rst_err", 64'(load_err), 0);
      chk("rst_xsum", 64'(load_xsum), 0);
      chk("rst_tbl_zero", 64'(sbox_in == '0), 1);
      reset = 1'b0;
      @(negedge clk);

      v0 = vld_cnt;
      load(0, 1'b0);
      chk("full_vld", 64'(sbox_in_vld), 1);
      chk("full_b0", 64'(sbox_in[7:0]), 64'h63);
      chk("full_b255", 64'(sbox_in[2047:2040]), 64'h16);
      chk("full_tbl", 64'(sbox_in == tbl_of(0)), 1);
      chk("full_xsum", 64'(load_xsum), 64'(xor_of(0)));
      @(negedge clk);
      chk("full_vld_drop", 64'(sbox_in_vld), 0);
      chk("full_ready_early", 64'(sbox_ready), 0);
      @(negedge clk);
      chk("full_ready", 64'(sbox_ready), 1);
      chk("full_latency", 64'(cyc - cyc_start + 1), 68);
      chk("full_lookup53", 64'(lut[8*8'h53 +: 8]), 64'hed);
      chk("full_vld_pulses", 64'(vld_cnt - v0), 1);
      load_word = 32'h12345678;
      load_word_vld = 1'b1;
      @(negedge clk);
      chk("ready_no_rdy", 64'(load_word_rdy), 0);
      chk("ready_xsum_hold", 64'(load_xsum), 64'(xor_of(0)));
      load_word_vld = 1'b0;

      load(1, 1'b0);
      chk("reload_ready_drop", 64'(ready_after_start), 0);
      chk("reload_tbl", 64'(sbox_in == tbl_of(1)), 1);
      repeat (2) @(negedge clk);
      chk("reload_ready", 64'(sbox_ready), 1);
      chk("reload_latency", 64'(cyc - cyc_start + 1), 68);
      chk("reload_lookup53", 64'(lut[8*8'h53 +: 8]), 64'h12);

      v0 = vld_cnt;
      load(0, 1'b1);
      chk("thr_vld", 64'(sbox_in_vld), 1);
      chk("thr_tbl", 64'(sbox_in == tbl_of(0)), 1);
      chk("thr_xsum", 64'(load_xsum), 64'(xor_of(0)));
      repeat (2) @(negedge clk);
      chk("thr_ready", 64'(sbox_ready), 1);
      chk("thr_vld_pulses", 64'(vld_cnt - v0), 1);

      v0 = vld_cnt;
      start();
      for (int k = 0; k < 20; k++) send(word_of(0, k));
      load_start = 1'b1;
      load_word = 32'hdeadbeef;
      @(negedge clk);
      load_start = 1'b0;
      chk("rst_load_xsum_clr", 64'(load_xsum), 0);
      chk("rst_load_rdy", 64'(load_word_rdy), 1);
      for (int k = 0; k < 64; k++) send(32'ha5a5a5a5);
      load_word_vld = 1'b0;
      chk("restart_vld", 64'(sbox_in_vld), 1);
      repeat (2) @(negedge clk);
      chk("restart_tbl", 64'(sbox_in == tbl_of(2)), 1);
      chk("restart_xsum", 64'(load_xsum), 0);
      chk("restart_vld_pulses", 64'(vld_cnt - v0), 1);
      chk("restart_ready", 64'(sbox_ready), 1);

      ack_en = 1'b0;
      load(0, 1'b0);
      repeat (8) @(negedge clk);
      chk("to_err_early", 64'(load_err), 0);
      @(negedge clk);
      chk("to_err", 64'(load_err), 1);
      chk("to_ready", 64'(sbox_ready), 0);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", 64'(load_err), 1);
      ack_en = 1'b1;
      start();
      chk("to_err_clear", 64'(load_err), 0);

      for (int k = 0; k < 30; k++) send(word_of(1, k));
      load_word_vld = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_rdy", 64'(load_word_rdy), 0);
      chk("arst_xsum", 64'(load_xsum), 0);
      chk("arst_tbl", 64'(sbox_in == '0), 1);
      chk("arst_ready_err", 64'({sbox_ready, load_err, sbox_in_vld}), 0);
      @(negedge clk);
      reset = 1'b0;
      load_word = 32'hcafef00d;
      load_word_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_rdy", 64'(load_word_rdy), 0);
      end
      chk("post_rst_xsum", 64'(load_xsum), 0);
      chk("post_rst_tbl", 64'(sbox_in == '0), 1);
      load_word_vld = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
